// File: rtl/iffifo_stream_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iffifo_stream_bridge_pkg
// Description : Shared types and constants for the IFFIFO stream bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package iffifo_stream_bridge_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 16;

    localparam logic [31:0] DEFAULT_FIFO_IN_OFFSET  = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_FIFO_OUT_OFFSET = 32'h0000_0004;
    localparam logic [3:0]  FULL_WSTRB              = 4'hF;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } iffifo_reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } iffifo_reg_rsp_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_READ   = 2'd2,
        ST_SETTLE = 2'd3
    } bridge_state_e;

    typedef enum logic {
        GRANT_WRITE = 1'b0,
        GRANT_READ  = 1'b1
    } grant_e;

    // Round-robin tie break: the side that did not win last time goes next.
    function automatic grant_e rr_pick(input grant_e last_grant);
        return (last_grant == GRANT_READ) ? GRANT_WRITE : GRANT_READ;
    endfunction

endpackage
`default_nettype wire

// File: rtl/iffifo_bridge_stage.sv
`default_nettype none
// ============================================================================
// Module      : iffifo_bridge_stage
// Description : One-entry valid/data holding register with load/clear handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module iffifo_bridge_stage #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_clear,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             valid_q;
    logic             valid_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Load wins over clear so a same-cycle drain and refill keeps the entry.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (i_clear) begin
            valid_d = 1'b0;
        end
        if (i_load) begin
            valid_d = 1'b1;
            data_d  = i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign o_valid = valid_q;
    assign o_data  = data_q;

endmodule
`default_nettype wire

// File: rtl/iffifo_stream_bridge.sv
`default_nettype none
// ============================================================================
// Module      : iffifo_stream_bridge
// Description : Register-bus initiator moving stream beats into FIFO_IN and
//               FIFO_OUT words out to a stream, one bus access at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module iffifo_stream_bridge
    import iffifo_stream_bridge_pkg::*;
#(
    parameter type         reg_req_t       = iffifo_reg_req_t,
    parameter type         reg_rsp_t       = iffifo_reg_rsp_t,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter logic [31:0] FIFO_IN_OFFSET  = DEFAULT_FIFO_IN_OFFSET,
    parameter logic [31:0] FIFO_OUT_OFFSET = DEFAULT_FIFO_OUT_OFFSET
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output reg_req_t          reg_req_o,
    input  reg_rsp_t          reg_rsp_i,
    input  logic              iffifo_in_ready_i,
    input  logic              iffifo_out_valid_i,
    input  logic              enable_i,
    input  logic [DATA_W-1:0] s_data_i,
    input  logic              s_valid_i,
    output logic              s_ready_o,
    output logic [DATA_W-1:0] m_data_o,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic              err_o,
    input  logic              err_clr_i,
    output logic [CNT_W-1:0]  wr_count_o,
    output logic [CNT_W-1:0]  rd_count_o
);

    localparam logic [31:0] FIFO_IN_ADDR  = BASE_ADDR + FIFO_IN_OFFSET;
    localparam logic [31:0] FIFO_OUT_ADDR = BASE_ADDR + FIFO_OUT_OFFSET;

    bridge_state_e     state_q;
    bridge_state_e     state_d;
    grant_e            last_grant_q;
    grant_e            last_grant_d;
    logic              err_q;
    logic              err_d;
    logic [CNT_W-1:0]  wr_count_q;
    logic [CNT_W-1:0]  wr_count_d;
    logic [CNT_W-1:0]  rd_count_q;
    logic [CNT_W-1:0]  rd_count_d;

    logic              in_full;
    logic [DATA_W-1:0] in_data;
    logic              in_load;
    logic              in_clear;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_load;
    logic              out_clear;

    logic              wr_cand;
    logic              rd_cand;
    logic              wr_done;
    logic              rd_done;
    logic              bus_err;

    assign wr_done = (state_q == ST_WRITE) && reg_rsp_i.ready;
    assign rd_done = (state_q == ST_READ)  && reg_rsp_i.ready;
    assign bus_err = (wr_done || rd_done) && reg_rsp_i.error;

    // Acceptance looks only at the registered fill state, so the entry being
    // written out cannot be refilled on its own completion cycle.
    assign in_load   = s_valid_i && !in_full;
    assign in_clear  = wr_done;
    assign out_load  = rd_done && !reg_rsp_i.error;
    assign out_clear = out_valid && m_ready_i;

    iffifo_bridge_stage #(
        .WIDTH (DATA_W)
    ) u_in_stage (
        .clk     (clk_i),
        .rst     (rst_i),
        .i_load  (in_load),
        .i_data  (s_data_i),
        .i_clear (in_clear),
        .o_valid (in_full),
        .o_data  (in_data)
    );

    iffifo_bridge_stage #(
        .WIDTH (DATA_W)
    ) u_out_stage (
        .clk     (clk_i),
        .rst     (rst_i),
        .i_load  (out_load),
        .i_data  (reg_rsp_i.rdata),
        .i_clear (out_clear),
        .o_valid (out_valid),
        .o_data  (out_data)
    );

    assign wr_cand = enable_i && in_full && iffifo_in_ready_i;
    assign rd_cand = enable_i && !out_valid && iffifo_out_valid_i;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_IDLE: begin
                if (wr_cand && (!rd_cand || rr_pick(last_grant_q) == GRANT_WRITE)) begin
                    state_d      = ST_WRITE;
                    last_grant_d = GRANT_WRITE;
                end else if (rd_cand) begin
                    state_d      = ST_READ;
                    last_grant_d = GRANT_READ;
                end
            end
            ST_WRITE: begin
                if (reg_rsp_i.ready) begin
                    state_d = ST_SETTLE;
                end
            end
            ST_READ: begin
                if (reg_rsp_i.ready) begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Request fields derive from the state and the held input entry only,
    // which keeps them stable for the whole wait-state window.
    always_comb begin
        reg_req_o = '0;
        case (state_q)
            ST_WRITE: begin
                reg_req_o.valid = 1'b1;
                reg_req_o.write = 1'b1;
                reg_req_o.addr  = FIFO_IN_ADDR;
                reg_req_o.wdata = in_data;
                reg_req_o.wstrb = FULL_WSTRB;
            end
            ST_READ: begin
                reg_req_o.valid = 1'b1;
                reg_req_o.write = 1'b0;
                reg_req_o.addr  = FIFO_OUT_ADDR;
            end
            default: begin
                reg_req_o.valid = 1'b0;
            end
        endcase
    end

    always_comb begin
        err_d = err_q;
        if (bus_err) begin
            err_d = 1'b1;
        end else if (err_clr_i) begin
            err_d = 1'b0;
        end
        wr_count_d = wr_count_q + CNT_W'(wr_done && !reg_rsp_i.error);
        rd_count_d = rd_count_q + CNT_W'(rd_done && !reg_rsp_i.error);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GRANT_READ;
            err_q        <= 1'b0;
            wr_count_q   <= '0;
            rd_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            err_q        <= err_d;
            wr_count_q   <= wr_count_d;
            rd_count_q   <= rd_count_d;
        end
    end

    assign s_ready_o  = !in_full;
    assign m_valid_o  = out_valid;
    assign m_data_o   = out_data;
    assign err_o      = err_q;
    assign wr_count_o = wr_count_q;
    assign rd_count_o = rd_count_q;

endmodule
`default_nettype wire

// File: tb/tb_iffifo_stream_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_iffifo_stream_bridge
// Description : Directed and randomized bench for iffifo_stream_bridge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iffifo_stream_bridge;
    import iffifo_stream_bridge_pkg::*;

    localparam logic [31:0] BASE = 32'h4000_1000;

    logic            clk = 1'b0;
    logic            rst;
    iffifo_reg_req_t req;
    iffifo_reg_rsp_t rsp;
    logic            in_ready, out_valid, enable;
    logic            s_valid, s_ready, m_valid, m_ready, err, err_clr;
    logic [31:0]     s_data, m_data;
    logic [15:0]     wr_count, rd_count;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    always #5 clk = ~clk;

    iffifo_stream_bridge #(
        .reg_req_t       (iffifo_reg_req_t),
        .reg_rsp_t       (iffifo_reg_rsp_t),
        .BASE_ADDR       (BASE),
        .FIFO_IN_OFFSET  (32'h0),
        .FIFO_OUT_OFFSET (32'h4)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .reg_req_o          (req),
        .reg_rsp_i          (rsp),
        .iffifo_in_ready_i  (in_ready),
        .iffifo_out_valid_i (out_valid),
        .enable_i           (enable),
        .s_data_i           (s_data),
        .s_valid_i          (s_valid),
        .s_ready_o          (s_ready),
        .m_data_o           (m_data),
        .m_valid_o          (m_valid),
        .m_ready_i          (m_ready),
        .err_o              (err),
        .err_clr_i          (err_clr),
        .wr_count_o         (wr_count),
        .rd_count_o         (rd_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // owner: which bus access is outstanding (0 none, 1 write, 2 read, 3 cool-down)
    int          owner;
    bit          prefer_read;      // true when the previous grant went to the write side
    bit          in_held;
    logic [31:0] in_word;
    logic [31:0] out_q[$];
    bit          sticky_err;
    logic [15:0] mdl_wr, mdl_rd;

    always @(posedge clk) begin
        bit done, want_w, want_r, take;
        if (rst) begin
            owner = 0; prefer_read = 1'b0; in_held = 1'b0; in_word = '0;
            out_q.delete(); sticky_err = 1'b0; mdl_wr = '0; mdl_rd = '0;
        end else begin
            done   = (owner == 1 || owner == 2) && rsp.ready;
            take   = s_valid && !in_held;
            want_w = enable && in_held && in_ready;
            want_r = enable && (out_q.size() == 0) && out_valid;
            if (done && rsp.error) sticky_err = 1'b1;
            else if (err_clr) sticky_err = 1'b0;
            if (out_q.size() != 0 && m_ready) void'(out_q.pop_front());
            if (done && owner == 1) begin
                in_held = 1'b0;
                if (!rsp.error) mdl_wr = mdl_wr + 16'd1;
            end
            if (done && owner == 2 && !rsp.error) begin
                out_q.push_back(rsp.rdata);
                mdl_rd = mdl_rd + 16'd1;
            end
            if (take) begin
                in_held = 1'b1;
                in_word = s_data;
            end
            if (owner == 3) owner = 0;
            else if (done) owner = 3;
            else if (owner == 0) begin
                if (want_w && (!want_r || !prefer_read)) begin owner = 1; prefer_read = 1'b1; end
                else if (want_r) begin owner = 2; prefer_read = 1'b0; end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("req_valid", 32'(req.valid), 32'(owner == 1 || owner == 2));
            if (owner == 1) begin
                check("req_write", 32'(req.write), 32'd1);
                check("req_addr_w", req.addr, BASE);
                check("req_wdata", req.wdata, in_word);
                check("req_wstrb", 32'(req.wstrb), 32'hF);
            end
            if (owner == 2) begin
                check("req_write_r", 32'(req.write), 32'd0);
                check("req_addr_r", req.addr, BASE + 32'h4);
            end
            check("s_ready", 32'(s_ready), 32'(!in_held));
            check("m_valid", 32'(m_valid), 32'(out_q.size() != 0));
            if (out_q.size() != 0) check("m_data", m_data, out_q[0]);
            check("err", 32'(err), 32'(sticky_err));
            check("wr_count", 32'(wr_count), 32'(mdl_wr));
            check("rd_count", 32'(rd_count), 32'(mdl_rd));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        in_ready = 1'b0; out_valid = 1'b0; enable = 1'b0;
        s_valid = 1'b0; s_data = '0; m_ready = 1'b0; err_clr = 1'b0;
        rsp = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive_idle();
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Loads one beat into the input entry while no grant can happen.
    task automatic preload(input logic [31:0] word);
        enable = 1'b0; s_valid = 1'b1; s_data = word;
        tick();
        s_valid = 1'b0;
    endtask

    initial begin
        logic [3:0] order;
        bit         grants[$];
        bit         prev_v;
        int         b2b;

        rst = 1'b1;
        drive_idle();
        tick();
        chk_en = 1'b1;
        tick();
        @(negedge clk);
        check("rst_s_ready", 32'(s_ready), 32'd1);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_req_valid", 32'(req.valid), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_wr_count", 32'(wr_count), 32'd0);
        rst = 1'b0;

        // single write, zero-wait responder
        do_reset();
        enable = 1'b1; in_ready = 1'b1; rsp.ready = 1'b1;
        s_valid = 1'b1; s_data = 32'hCAFE_0001;
        tick();
        s_valid = 1'b0;
        @(negedge clk);
        check("t1_s_ready_low", 32'(s_ready), 32'd0);
        tick();
        @(negedge clk);
        check("t1_valid", 32'(req.valid), 32'd1);
        check("t1_addr", req.addr, 32'h4000_1000);
        check("t1_wdata", req.wdata, 32'hCAFE_0001);
        check("t1_wstrb", 32'(req.wstrb), 32'hF);
        tick();
        @(negedge clk);
        check("t1_wr_count", 32'(wr_count), 32'd1);
        check("t1_settle", 32'(req.valid), 32'd0);
        check("t1_s_ready_back", 32'(s_ready), 32'd1);

        // single read, held output
        do_reset();
        enable = 1'b1; out_valid = 1'b1; rsp.ready = 1'b1; rsp.rdata = 32'h1234_5678;
        tick();
        @(negedge clk);
        check("t2_addr", req.addr, 32'h4000_1004);
        check("t2_write", 32'(req.write), 32'd0);
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t2_m_valid", 32'(m_valid), 32'd1);
            check("t2_m_data", m_data, 32'h1234_5678);
            check("t2_no_reread", 32'(req.valid), 32'd0);
            tick();
        end
        @(negedge clk);
        check("t2_rd_count", 32'(rd_count), 32'd1);
        m_ready = 1'b1; out_valid = 1'b0;
        tick();
        @(negedge clk);
        check("t2_drained", 32'(m_valid), 32'd0);

        // tie arbitration
        do_reset();
        in_ready = 1'b1; out_valid = 1'b1; m_ready = 1'b1; rsp.ready = 1'b1;
        rsp.rdata = 32'h0BAD_F00D;
        preload(32'h3000_0000);
        s_valid = 1'b1; enable = 1'b1;
        prev_v = 1'b0; b2b = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (req.valid) grants.push_back(req.write);
            if (req.valid && prev_v) b2b++;
            prev_v = req.valid;
            tick();
            s_data = s_data + 32'd1;
        end
        order = 4'bxxxx;
        if (grants.size() >= 4) order = {grants[0], grants[1], grants[2], grants[3]};
        check("t3_order_WRWR", 32'(order), 32'(4'b1010));
        check("t3_settle_gap", 32'(b2b), 32'd0);

        // wait states
        do_reset();
        preload(32'hA5A5_0004);
        enable = 1'b1; in_ready = 1'b1; rsp.ready = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_hold_valid", 32'(req.valid), 32'd1);
            check("t4_hold_wdata", req.wdata, 32'hA5A5_0004);
            check("t4_hold_addr", req.addr, 32'h4000_1000);
            tick();
        end
        rsp.ready = 1'b1;
        tick();
        rsp.ready = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        @(negedge clk);
        check("t4_one_completion", 32'(wr_count), 32'd1);

        // bus errors
        do_reset();
        preload(32'hDEAD_0005);
        enable = 1'b1; in_ready = 1'b1; rsp.ready = 1'b1; rsp.error = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("t5_err_w", 32'(err), 32'd1);
        check("t5_wr_count", 32'(wr_count), 32'd0);
        check("t5_dropped", 32'(s_ready), 32'd1);
        in_ready = 1'b0; out_valid = 1'b1; rsp.rdata = 32'h00BA_DBAD;
        tick();
        tick();
        tick();
        out_valid = 1'b0;
        @(negedge clk);
        check("t5_no_m_valid", 32'(m_valid), 32'd0);
        check("t5_rd_count", 32'(rd_count), 32'd0);
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        @(negedge clk);
        check("t5_cleared", 32'(err), 32'd0);
        out_valid = 1'b1; err_clr = 1'b1;
        tick();
        tick();
        out_valid = 1'b0;
        @(negedge clk);
        check("t5_set_beats_clear", 32'(err), 32'd1);
        tick();
        err_clr = 1'b0; rsp.error = 1'b0;
        @(negedge clk);
        check("t5_clear_after", 32'(err), 32'd0);

        // reset mid-write, then counter wrap
        do_reset();
        preload(32'h6000_0006);
        enable = 1'b1; in_ready = 1'b1; rsp.ready = 1'b0;
        tick();
        @(negedge clk);
        check("t6_in_write", 32'(req.valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0; enable = 1'b0; in_ready = 1'b0;
        @(negedge clk);
        check("t6_abort_valid", 32'(req.valid), 32'd0);
        check("t6_abort_s_ready", 32'(s_ready), 32'd1);
        check("t6_abort_count", 32'(wr_count), 32'd0);
        #1;
        force dut.wr_count_q = 16'hFFFF;
        mdl_wr = 16'hFFFF;
        tick();
        release dut.wr_count_q;
        @(negedge clk);
        check("t6_preload", 32'(wr_count), 32'h0000_FFFF);
        preload(32'h6000_0007);
        enable = 1'b1; in_ready = 1'b1; rsp.ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("t6_wrap", 32'(wr_count), 32'd0);

        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            enable    = ($urandom_range(0, 9) != 0);
            s_valid   = ($urandom_range(0, 1) == 1);
            s_data    = $urandom;
            in_ready  = ($urandom_range(0, 3) != 0);
            out_valid = ($urandom_range(0, 3) != 0);
            m_ready   = ($urandom_range(0, 2) != 0);
            rsp.ready = ($urandom_range(0, 2) != 0);
            rsp.error = ($urandom_range(0, 9) == 0);
            rsp.rdata = $urandom;
            err_clr   = ($urandom_range(0, 15) == 0);
            tick();
        end
        drive_idle();
        tick();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
